// File: rtl/ascii_num_sep_ctrl.sv
// Session sequencer for the ASCII number separator: clears the separator
// buffer, forwards one payload packet, checks the parsed count and drains
// the separator RAM as an indexed number stream.
// Optional watchdog: define ASCII_SEP_CTRL_TIMEOUT_EN.
module ascii_num_sep_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] expected_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  sep_buf_clear,
  output logic [7:0]            sep_data,
  output logic                  sep_valid,
  output logic                  sep_last,
  input  logic                  sep_ready,
  input  logic                  sep_done,
  input  logic                  sep_invalid,
  input  logic [ADDR_WIDTH-1:0] sep_num_count,
  output logic [ADDR_WIDTH-1:0] sep_rd_addr,
  input  logic [DATA_WIDTH-1:0] sep_rd_data,
  output logic [DATA_WIDTH-1:0] num_data,
  output logic [ADDR_WIDTH-1:0] num_idx,
  output logic                  num_valid,
  input  logic                  num_ready,
  output logic                  num_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned LW = $clog2(RD_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECV,
    S_WAIT,
    S_DRAIN_RD,
    S_DRAIN_OUT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] exp_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         clr_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [DATA_WIDTH-1:0] num_data_q;
  logic                  done_q;
  logic                  error_q;
  logic [1:0]            err_code_q;

  logic       idle_like;
  logic       start_ok;
  logic       hs_in;
  logic       rd_cap;
  logic       last_idx;
  logic       timeout_hit;
  logic       fin_ok;
  logic       fin_err;
  logic [1:0] fin_code;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign start_ok  = start && idle_like;
  assign hs_in     = (state == S_RECV) && in_valid && sep_ready;
  assign rd_cap    = (state == S_DRAIN_RD) && (lat_cnt == LW'(RD_LAT - 1));
  assign last_idx  = (rd_addr == exp_cnt - 1'b1);

`ifdef ASCII_SEP_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_active;

  assign to_active   = (state == S_RECV) || (state == S_WAIT);
  assign timeout_hit = to_active && !hs_in && (to_cnt == TW'(TIMEOUT_CYC - 1));

  // watchdog: counts idle RECV/WAIT cycles, restarts on every accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (to_active && !hs_in) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next-state and session result decode
  always_comb begin
    state_d  = state;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    fin_code = 2'd0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_cnt == CW'(DEPTH - 1)) state_d = S_RECV;
      end
      S_RECV, S_WAIT: begin
        // an early sep_done during RECV takes priority over the last beat
        if (sep_done) begin
          if (sep_invalid) begin
            fin_err  = 1'b1;
            fin_code = 2'd1;
          end else if (sep_num_count != exp_cnt) begin
            fin_err  = 1'b1;
            fin_code = 2'd2;
          end else if (exp_cnt == '0) begin
            fin_ok = 1'b1;
          end else begin
            state_d = S_DRAIN_RD;
          end
        end else if (timeout_hit) begin
          fin_err  = 1'b1;
          fin_code = 2'd3;
        end else if (hs_in && in_last) begin
          state_d = S_WAIT;
        end
        if (fin_err) state_d = S_ERROR;
        if (fin_ok)  state_d = S_DONE;
      end
      S_DRAIN_RD: begin
        if (rd_cap) state_d = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (num_ready) begin
          if (last_idx) begin
            state_d = S_DONE;
            fin_ok  = 1'b1;
          end else begin
            state_d = S_DRAIN_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // session datapath: counters, read address, captured number, status
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_cnt    <= '0;
      rd_addr    <= '0;
      clr_cnt    <= '0;
      lat_cnt    <= '0;
      num_data_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      if (start_ok) begin
        exp_cnt    <= expected_count;
        rd_addr    <= '0;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
        err_code_q <= 2'd0;
      end
      if (fin_ok) done_q <= 1'b1;
      if (fin_err) begin
        error_q    <= 1'b1;
        err_code_q <= fin_code;
      end
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
      lat_cnt <= (state == S_DRAIN_RD) ? lat_cnt + 1'b1 : '0;
      if (rd_cap) num_data_q <= sep_rd_data;
      if ((state == S_DRAIN_OUT) && num_ready && !last_idx) rd_addr <= rd_addr + 1'b1;
    end
  end

  assign in_ready      = (state == S_RECV) && sep_ready;
  assign sep_valid     = (state == S_RECV) && in_valid;
  assign sep_last      = (state == S_RECV) && in_last;
  assign sep_data      = (state == S_RECV) ? in_data : '0;
  assign sep_buf_clear = (state == S_CLEAR) && (clr_cnt == '0);
  assign sep_rd_addr   = rd_addr;
  assign num_data      = num_data_q;
  assign num_idx       = rd_addr;
  assign num_valid     = (state == S_DRAIN_OUT);
  assign num_last      = (state == S_DRAIN_OUT) && last_idx;
  assign busy          = !idle_like;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

endmodule
